// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a sticky
// fault/halt state for misaligned redirects or fetches past the end of memory.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam int unsigned WORD_AW = 30;
  localparam logic [WORD_AW-1:0] MEM_LIMIT = WORD_AW'(MEM_WORDS);
  localparam logic [WORD_AW-1:0] RESET_WORD = RESET_PC[31:2];

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e state_q, state_d;

  // PC kept as a word address so the byte offset is structurally zero.
  logic [WORD_AW-1:0] pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        ifpc_q, ifpc_d;
  logic [31:0]        ifpc4_q, ifpc4_d;
  logic               fault_q, fault_d;
  logic [31:0]        count_q, count_d;

  logic               misaligned_c;
  logic               out_of_range_c;
  logic [WORD_AW-1:0] pc_next_word_c;

  assign misaligned_c   = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign out_of_range_c = !redirect_valid && (pc_q >= MEM_LIMIT);
  assign pc_next_word_c = pc_q + WORD_AW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_WORD;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      ifpc_q  <= 32'h0;
      ifpc4_q <= 32'h0;
      fault_q <= 1'b0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc4_q <= ifpc4_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  // Next-state: fault > redirect > stall > advance; HALT freezes everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ifpc4_d = ifpc4_q;
    fault_d = fault_q;
    count_d = count_q;

    unique case (state_q)
      ST_RUN: begin
        if (misaligned_c || out_of_range_c) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
          valid_d = 1'b0;
        end else if (redirect_valid) begin
          pc_d    = redirect_pc[31:2];
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = instr_in;
          ifpc_d  = {pc_q, 2'b00};
          ifpc4_d = {pc_next_word_c, 2'b00};
          valid_d = 1'b1;
          pc_d    = pc_next_word_c;
          count_d = count_q + 32'd1;
        end
      end
      ST_HALT: begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
      default: begin
        state_d = ST_HALT;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
    endcase
  end

  assign pc          = {pc_q, 2'b00};
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = ifpc_q;
  assign if_pc4      = ifpc4_q;
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, stall, redirect, faults
// and asynchronous reset, against a combinational instruction memory model.
module tb_instr_fetch;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_in;
  logic [31:0] pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        fault;
  logic [31:0] fetch_count;

  int passed;
  int total;

  instr_fetch #(.RESET_PC(32'h0000_0000), .MEM_WORDS(64)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_in       (instr_in),
    .pc             (pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word n holds 0xC0DE_0000 + n.
  assign instr_in = 32'hC0DE_0000 + {2'b00, pc[31:2]};

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    reset_n = 1'b0;
    #12;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    reset_n = 1'b0;
    #3;
    total++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc, 32'h0); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", if_valid); else passed++;
    total++; if (if_instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", if_instr); else passed++;
    total++; if (if_pc !== 32'h0 || if_pc4 !== 32'h0) $display("FAIL reset_ifpc: got %h/%h want 0/0", if_pc, if_pc4); else passed++;
    total++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else passed++;
    total++; if (fetch_count !== 32'h0) $display("FAIL reset_count: got %h want 0", fetch_count); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_instr [4];
    logic [31:0] exp_pc [4];
    exp_instr = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
    exp_pc    = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (if_instr !== exp_instr[i] || if_valid !== 1'b1)
        $display("FAIL seq_instr[%0d]: got %h v=%b want %h v=1", i, if_instr, if_valid, exp_instr[i]); else passed++;
      total++; if (if_pc !== exp_pc[i] || if_pc4 !== exp_pc[i] + 32'd4)
        $display("FAIL seq_ifpc[%0d]: got %h/%h want %h/%h", i, if_pc, if_pc4, exp_pc[i], exp_pc[i] + 32'd4); else passed++;
    end
    total++; if (fetch_count !== 32'd4) $display("FAIL seq_count: got %0d want 4", fetch_count); else passed++;
    total++; if (pc !== 32'h10) $display("FAIL seq_pc: got %h want 00000010", pc); else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (if_instr !== 32'hC0DE_0001 || if_pc !== 32'h4 || if_valid !== 1'b1)
        $display("FAIL stall_hold_instr[%0d]: got %h pc %h v=%b want C0DE0001 pc 4 v=1", i, if_instr, if_pc, if_valid); else passed++;
      total++; if (pc !== 32'h8 || fetch_count !== 32'd2)
        $display("FAIL stall_hold_pc[%0d]: got pc %h cnt %0d want 8 / 2", i, pc, fetch_count); else passed++;
    end
    stall = 1'b0;
    step();
    total++; if (if_instr !== 32'hC0DE_0002 || if_pc !== 32'h8 || fetch_count !== 32'd3)
      $display("FAIL stall_release: got %h pc %h cnt %0d want C0DE0002 pc 8 cnt 3", if_instr, if_pc, fetch_count); else passed++;
  endtask

  task automatic test_redirect_stall();
    do_reset();
    for (int i = 0; i < 4; i++) step();
    total++; if (pc !== 32'h10) $display("FAIL redir_setup_pc: got %h want 00000010", pc); else passed++;
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h4;
    step();
    total++; if (pc !== 32'h4 || if_valid !== 1'b0 || fetch_count !== 32'd4)
      $display("FAIL redir_flush: got pc %h v=%b cnt %0d want 4 v=0 cnt 4", pc, if_valid, fetch_count); else passed++;
    stall = 1'b0;
    redirect_valid = 1'b0;
    step();
    total++; if (if_instr !== 32'hC0DE_0001 || if_pc !== 32'h4 || if_pc4 !== 32'h8 || if_valid !== 1'b1)
      $display("FAIL redir_target: got %h pc %h pc4 %h v=%b want C0DE0001 4 8 1", if_instr, if_pc, if_pc4, if_valid); else passed++;
    total++; if (fetch_count !== 32'd5 || pc !== 32'h8)
      $display("FAIL redir_count: got cnt %0d pc %h want 5 / 8", fetch_count, pc); else passed++;
  endtask

  task automatic test_misaligned();
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h6;
    step();
    total++; if (fault !== 1'b1 || if_valid !== 1'b0 || pc !== 32'h4)
      $display("FAIL misalign_fault: got f=%b v=%b pc %h want 1 0 4", fault, if_valid, pc); else passed++;
    redirect_pc = 32'h0;
    step();
    step();
    total++; if (fault !== 1'b1 || pc !== 32'h4 || fetch_count !== 32'd1 || if_instr !== 32'hC0DE_0000)
      $display("FAIL misalign_halt: got f=%b pc %h cnt %0d instr %h want 1 4 1 C0DE0000", fault, pc, fetch_count, if_instr); else passed++;
    redirect_valid = 1'b0;
  endtask

  task automatic test_range();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hF8;
    step();
    redirect_valid = 1'b0;
    total++; if (pc !== 32'hF8 || if_valid !== 1'b0) $display("FAIL range_redir: got pc %h v=%b want F8 0", pc, if_valid); else passed++;
    step();
    total++; if (if_instr !== 32'hC0DE_003E || if_pc !== 32'hF8 || fetch_count !== 32'd1)
      $display("FAIL range_w3e: got %h pc %h cnt %0d want C0DE003E F8 1", if_instr, if_pc, fetch_count); else passed++;
    step();
    total++; if (if_instr !== 32'hC0DE_003F || pc !== 32'h100 || fetch_count !== 32'd2 || fault !== 1'b0)
      $display("FAIL range_w3f: got %h pc %h cnt %0d f=%b want C0DE003F 100 2 0", if_instr, pc, fetch_count, fault); else passed++;
    step();
    total++; if (fault !== 1'b1 || if_valid !== 1'b0 || pc !== 32'h100 || fetch_count !== 32'd2)
      $display("FAIL range_fault: got f=%b v=%b pc %h cnt %0d want 1 0 100 2", fault, if_valid, pc, fetch_count); else passed++;
    stall = 1'b1;
    step();
    stall = 1'b0;
    step();
    total++; if (fault !== 1'b1 || fetch_count !== 32'd2 || if_instr !== 32'hC0DE_003F || if_pc4 !== 32'h100)
      $display("FAIL range_frozen: got f=%b cnt %0d instr %h pc4 %h want 1 2 C0DE003F 100", fault, fetch_count, if_instr, if_pc4); else passed++;
  endtask

  task automatic test_async_reset();
    // Entered from HALT left by test_range.
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (pc !== 32'h0 || if_valid !== 1'b0 || fault !== 1'b0 || fetch_count !== 32'h0)
      $display("FAIL async_reset: got pc %h v=%b f=%b cnt %0d want 0 0 0 0", pc, if_valid, fault, fetch_count); else passed++;
    total++; if (if_instr !== 32'h0 || if_pc !== 32'h0 || if_pc4 !== 32'h0)
      $display("FAIL async_reset_ifid: got %h %h %h want 0 0 0", if_instr, if_pc, if_pc4); else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    total++; if (if_instr !== 32'hC0DE_0000 || if_pc !== 32'h0 || if_valid !== 1'b1 || pc !== 32'h4 || fetch_count !== 32'd1)
      $display("FAIL async_first_fetch: got %h pc %h v=%b npc %h cnt %0d want C0DE0000 0 1 4 1", if_instr, if_pc, if_valid, pc, fetch_count); else passed++;
  endtask

  task automatic test_out_of_range_redirect();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    total++; if (pc !== 32'h200 || fault !== 1'b0) $display("FAIL oor_accept: got pc %h f=%b want 200 0", pc, fault); else passed++;
    step();
    total++; if (fault !== 1'b1 || pc !== 32'h200 || fetch_count !== 32'd0)
      $display("FAIL oor_fault: got f=%b pc %h cnt %0d want 1 200 0", fault, pc, fetch_count); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_misaligned();
    test_range();
    test_async_reset();
    test_out_of_range_redirect();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
